// File: rtl/regbank_pkg.sv
// Shared constants, FSM state type and write-enable helper for the register bank read side.
package regbank_pkg;

  localparam int DW   = 32;
  localparam int NREG = 16;
  localparam int AW   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_DUMP
  } state_t;

  // The bank only commits a write when exactly one enable bit is set.
  function automatic logic onehot_valid(input logic [NREG-1:0] wr_en);
    return (wr_en != '0) && ((wr_en & (wr_en - NREG'(1))) == '0);
  endfunction

endpackage

// File: rtl/regbank_fwd_mux.sv
// Combinational register select with same-cycle write forwarding.
module regbank_fwd_mux
  import regbank_pkg::*;
(
  input  logic [AW-1:0]      addr,
  input  logic [NREG*DW-1:0] regs_flat,
  input  logic [NREG-1:0]    wr_en,
  input  logic [DW-1:0]      wr_data,
  output logic [DW-1:0]      data
);

  logic fwd_hit;

  assign fwd_hit = onehot_valid(wr_en) && wr_en[addr];
  assign data    = fwd_hit ? wr_data : regs_flat[addr*DW +: DW];

endmodule

// File: rtl/regbank_read_port.sv
// Read side of the 16x32 register bank: two-operand read port with one cycle of latency,
// write forwarding, and a debug engine that streams all registers in index order.
module regbank_read_port
  import regbank_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [NREG*DW-1:0]  regs_flat,
  input  logic [NREG-1:0]     wr_en,
  input  logic [DW-1:0]       wr_data,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [AW-1:0]       req_addr_a,
  input  logic [AW-1:0]       req_addr_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DW-1:0]       rsp_data_a,
  output logic [DW-1:0]       rsp_data_b,
  input  logic                dump_start,
  output logic                dump_busy,
  output logic                dump_valid,
  input  logic                dump_ready,
  output logic [AW-1:0]       dump_idx,
  output logic [DW-1:0]       dump_data,
  output logic                dump_last
);

  state_t        state, state_next;
  logic [DW-1:0] fwd_a, fwd_b, fwd_dump;
  logic [AW-1:0] dump_addr;
  logic          req_fire;
  logic          dump_fire;
  logic          dump_at_end;

  regbank_fwd_mux u_fwd_a (
    .addr      (req_addr_a),
    .regs_flat (regs_flat),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .data      (fwd_a)
  );

  regbank_fwd_mux u_fwd_b (
    .addr      (req_addr_b),
    .regs_flat (regs_flat),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .data      (fwd_b)
  );

  // DRAIN loads word 0; DUMP preloads the next word so it is ready on the handshake.
  assign dump_addr = (state == ST_DUMP) ? dump_idx + AW'(1) : '0;

  regbank_fwd_mux u_fwd_dump (
    .addr      (dump_addr),
    .regs_flat (regs_flat),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .data      (fwd_dump)
  );

  assign req_fire    = req_valid && req_ready;
  assign dump_fire   = dump_valid && dump_ready;
  assign dump_at_end = (dump_idx == AW'(NREG - 1));
  assign dump_last   = dump_valid && dump_at_end;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    dump_busy  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = !rst && (!rsp_valid || rsp_ready);
        if (dump_start) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        dump_busy = 1'b1;
        if (!rsp_valid) state_next = ST_DUMP;
      end
      ST_DUMP: begin
        dump_busy = 1'b1;
        if (dump_fire && dump_at_end) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Response data is only written on accept, so it holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_data_a <= '0;
      rsp_data_b <= '0;
    end else if (req_fire) begin
      rsp_valid  <= 1'b1;
      rsp_data_a <= fwd_a;
      rsp_data_b <= fwd_b;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      dump_data  <= '0;
    end else begin
      case (state)
        ST_DRAIN: begin
          if (!rsp_valid) begin
            dump_valid <= 1'b1;
            dump_idx   <= '0;
            dump_data  <= fwd_dump;
          end
        end
        ST_DUMP: begin
          if (dump_fire) begin
            if (dump_at_end) begin
              dump_valid <= 1'b0;
            end else begin
              dump_idx  <= dump_idx + AW'(1);
              dump_data <= fwd_dump;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_read_port.sv
// Directed self-checking bench for regbank_read_port.
module tb_regbank_read_port;

  logic          clk = 1'b0;
  logic          rst;
  logic [511:0]  regs_flat;
  logic [15:0]   wr_en;
  logic [31:0]   wr_data;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_addr_a;
  logic [3:0]    req_addr_b;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_data_a;
  logic [31:0]   rsp_data_b;
  logic          dump_start;
  logic          dump_busy;
  logic          dump_valid;
  logic          dump_ready;
  logic [3:0]    dump_idx;
  logic [31:0]   dump_data;
  logic          dump_last;

  int checks = 0;
  int errors = 0;

  regbank_read_port dut (
    .clk        (clk),
    .rst        (rst),
    .regs_flat  (regs_flat),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr_a (req_addr_a),
    .req_addr_b (req_addr_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data_a (rsp_data_a),
    .rsp_data_b (rsp_data_b),
    .dump_start (dump_start),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .dump_last  (dump_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle so registered outputs can be sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reg(input int i, input logic [31:0] v);
    regs_flat[i*32 +: 32] = v;
  endtask

  // Runs the dump stream to completion, checking order, data and last flag.
  task automatic run_dump(input bit toggle_ready, input string tag);
    int n = 0;
    int cyc = 0;
    while (n < 16 && cyc < 200) begin
      dump_ready = toggle_ready ? cyc[0] : 1'b1;
      #1;
      check({tag, "_req_ready_low"}, 32'(req_ready), 32'd0);
      if (dump_valid && dump_ready) begin
        check({tag, "_idx"}, 32'(dump_idx), 32'(n));
        check({tag, "_data"}, dump_data, 32'h100 + 32'(n));
        check({tag, "_last"}, 32'(dump_last), 32'(n == 15));
        n++;
      end
      step();
      dump_start = 1'b0;
      cyc++;
    end
    check({tag, "_word_count"}, 32'(n), 32'd16);
    dump_ready = 1'b0;
    check({tag, "_busy_after"}, 32'(dump_busy), 32'd0);
    check({tag, "_valid_after"}, 32'(dump_valid), 32'd0);
    check({tag, "_req_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; regs_flat = '0; wr_en = '0; wr_data = '0;
    req_valid = 1'b0; req_addr_a = '0; req_addr_b = '0; rsp_ready = 1'b0;
    dump_start = 1'b0; dump_ready = 1'b0;
    step(); step();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_dump_busy", 32'(dump_busy), 32'd0);
    check("rst_dump_valid", 32'(dump_valid), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Basic read
    set_reg(3, 32'hDEADBEEF); set_reg(9, 32'h12345678);
    set_reg(1, 32'h11); set_reg(2, 32'h22); set_reg(4, 32'h44); set_reg(5, 32'h55);
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr_a = 4'd3; req_addr_b = 4'd9;
    step();
    req_valid = 1'b0;
    check("read_rsp_valid", 32'(rsp_valid), 32'd1);
    check("read_data_a", rsp_data_a, 32'hDEADBEEF);
    check("read_data_b", rsp_data_b, 32'h12345678);
    step();
    check("read_rsp_clear", 32'(rsp_valid), 32'd0);

    // Backpressure
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr_a = 4'd1; req_addr_b = 4'd2;
    step();
    req_addr_a = 4'd4; req_addr_b = 4'd4;
    for (int i = 0; i < 4; i++) begin
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_data_a", rsp_data_a, 32'h11);
      check("bp_data_b", rsp_data_b, 32'h22);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    check("bp_next_valid", 32'(rsp_valid), 32'd1);
    check("bp_next_a", rsp_data_a, 32'h44);
    check("bp_next_b", rsp_data_b, 32'h44);
    step();
    check("bp_drained", 32'(rsp_valid), 32'd0);

    // Reset mid-traffic
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr_a = 4'd3; req_addr_b = 4'd9;
    step();
    req_valid = 1'b0;
    check("pre_rst_valid", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    step();
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_data_a", rsp_data_a, 32'd0);
    check("mid_rst_data_b", rsp_data_b, 32'd0);
    step();
    rst = 1'b0; rsp_ready = 1'b1;
    #1;
    check("mid_rst_after_ready", 32'(req_ready), 32'd1);

    // Forwarding: one-hot write to reg5 forwards, multi-hot does not
    wr_en = 16'h0020; wr_data = 32'hCAFE0001;
    req_valid = 1'b1; req_addr_a = 4'd5; req_addr_b = 4'd3;
    step();
    check("fwd_hit_a", rsp_data_a, 32'hCAFE0001);
    check("fwd_hit_b", rsp_data_b, 32'hDEADBEEF);
    wr_en = 16'h0030; req_addr_b = 4'd4;
    step();
    check("fwd_multihot_a", rsp_data_a, 32'h55);
    check("fwd_multihot_b", rsp_data_b, 32'h44);
    wr_en = '0; req_valid = 1'b0;
    step();
    check("fwd_drained", 32'(rsp_valid), 32'd0);

    // Dump with toggling ready
    for (int i = 0; i < 16; i++) set_reg(i, 32'h100 + 32'(i));
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    check("dump_busy_drain", 32'(dump_busy), 32'd1);
    check("dump_req_ready_drain", 32'(req_ready), 32'd0);
    step();
    check("dump_first_valid", 32'(dump_valid), 32'd1);
    run_dump(1'b1, "dump1");

    // Dump requested with a read in the same cycle and the response stalled
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr_a = 4'd7; req_addr_b = 4'd8;
    dump_start = 1'b1;
    step();
    req_valid = 1'b0; dump_start = 1'b0;
    check("pend_rsp_valid", 32'(rsp_valid), 32'd1);
    check("pend_data_a", rsp_data_a, 32'h107);
    check("pend_data_b", rsp_data_b, 32'h108);
    for (int i = 0; i < 3; i++) begin
      check("pend_busy", 32'(dump_busy), 32'd1);
      check("pend_no_dump", 32'(dump_valid), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    check("pend_consumed", 32'(rsp_valid), 32'd0);
    check("pend_still_drain", 32'(dump_valid), 32'd0);
    step();
    check("pend_dump_valid", 32'(dump_valid), 32'd1);
    check("pend_dump_idx0", 32'(dump_idx), 32'd0);
    dump_start = 1'b1;
    run_dump(1'b0, "dump2");
    step();
    check("dump_start_ignored", 32'(dump_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
